// File: rtl/tensor_core_mma.sv
// tensor_core_mma
//   Outer-product matrix-multiply-accumulate engine. Each accepted beat adds
//   a_col (column k of A) times b_row (row k of B) onto the NxN accumulator
//   tile C. After the last beat the tile is drained one row per handshake.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake (ready only while accumulating)
//   in_a_col, in_b_row  : N packed DW-bit operand elements
//   in_first, in_acc    : start of tile; in_acc=1 keeps prior C as the base
//   in_last             : last beat of the tile, starts the drain
//   out_valid/out_ready : result row handshake
//   out_row             : N packed AW-bit elements of row out_row_idx
//   out_row_idx         : index of the row currently presented
//   out_last            : row N-1 is presented
//   out_ovf             : sticky clamp/wrap flag for the current tile
//   done                : one-cycle pulse after the final row handshake
module tensor_core_mma #(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_a_col,
    input  logic [N*DW-1:0]      in_b_row,
    input  logic                 in_first,
    input  logic                 in_acc,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      out_row,
    output logic [$clog2(N)-1:0] out_row_idx,
    output logic                 out_last,
    output logic                 out_ovf,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t        state, state_nxt;
    logic          accept_p0;
    logic          drain_hs;
    logic          final_hs;
    logic          ovf_any_p0;
    logic [AW-1:0] c_nxt_p0 [N][N];
    logic [AW-1:0] c_p1     [N][N];
    logic [IW-1:0] idx_p1;
    logic          ovf_p1;
    logic          done_p1;

    // Product extended to AW bits. Extending the operands first and keeping
    // the low AW bits of the product gives the correctly extended 2*DW result.
    function automatic logic [AW-1:0] ext_mul(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        if (SIGNED != 0)
            ext_mul = AW'($signed(a)) * AW'($signed(b));
        else
            ext_mul = AW'(a) * AW'(b);
    endfunction

    // Returns {overflow, result}; result clamps when SAT is set, else wraps.
    function automatic logic [AW:0] add_sat(input logic [AW-1:0] x,
                                            input logic [AW-1:0] y);
        logic [AW:0]   s;
        logic          o;
        logic [AW-1:0] r;
        if (SIGNED != 0) begin
            s = {x[AW-1], x} + {y[AW-1], y};
            o = s[AW] ^ s[AW-1];
            if (o && (SAT != 0))
                r = s[AW] ? SMIN : SMAX;
            else
                r = s[AW-1:0];
        end else begin
            s = {1'b0, x} + {1'b0, y};
            o = s[AW];
            if (o && (SAT != 0))
                r = '1;
            else
                r = s[AW-1:0];
        end
        add_sat = {o, r};
    endfunction

    // ---- stage p0: beat acceptance and per-element multiply-add ----
    assign accept_p0 = in_valid && (state == ACCUM);
    assign drain_hs  = (state == DRAIN) && out_ready;
    assign final_hs  = drain_hs && (idx_p1 == LAST_IDX);

    always_comb begin
        ovf_any_p0 = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [AW-1:0] base;
                logic [AW:0]   r;
                // A fresh tile without in_acc starts from zero and cannot overflow.
                base = (in_first && !in_acc) ? '0 : c_p1[i][j];
                r = add_sat(base, ext_mul(in_a_col[i*DW +: DW], in_b_row[j*DW +: DW]));
                c_nxt_p0[i][j] = r[AW-1:0];
                ovf_any_p0 = ovf_any_p0 | r[AW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept_p0 && in_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (final_hs)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // ---- stage p1: accumulator tile, drain index and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            idx_p1  <= '0;
            ovf_p1  <= 1'b0;
            done_p1 <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    c_p1[i][j] <= '0;
        end else begin
            state   <= state_nxt;
            done_p1 <= final_hs;
            if (accept_p0) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        c_p1[i][j] <= c_nxt_p0[i][j];
                // A beat without in_first continues the current tile's flag.
                ovf_p1 <= in_first ? ovf_any_p0 : (ovf_p1 | ovf_any_p0);
            end
            if (drain_hs)
                idx_p1 <= final_hs ? '0 : idx_p1 + 1'b1;
        end
    end

    always_comb begin
        out_row = '0;
        for (int j = 0; j < N; j++)
            out_row[j*AW +: AW] = c_p1[idx_p1][j];
    end

    assign out_row_idx = idx_p1;
    assign out_last    = (state == DRAIN) && (idx_p1 == LAST_IDX);
    assign out_ovf     = ovf_p1;
    assign done        = done_p1;

endmodule
